arcade_coin_seq: RTL
====================

// Module: arcade_coin_seq
// PURPOSE
//  Sequences coin inputs into the arcade core's active-low coin vector.
//  Keyboard/joystick coin presses from arcade_inputs arrive as raw levels of
//  arbitrary length. This block queues them and replays each one as a pulse
//  with a fixed frame-based width and gap, so the core's coin routine never
//  misses or double-counts a coin.
//  Sits between arcade_inputs (m_coinN, m_tilt) and the core (but_coin_s),
//  timed from the core's O_VBLANK.
// PARAMETERS
//  NCOIN        2   number of independent coin channels
//  HOLD_FRAMES  3   frame ticks the coin line stays asserted per coin (>=1)
//  GAP_FRAMES   3   frame ticks of forced release after each pulse (>=1)
//  PEND_W       2   width of per-channel pending counter; saturates at 2**PEND_W-1
// PORTS
//  clk_sys     in   1           system clock; single clock domain
//  reset       in   1           synchronous, active-high reset
//  vblank      in   1           core vertical blank level; rising edge = frame tick
//  coin_in     in   NCOIN       active-high raw coin levels (bit0 = coin1)
//  tilt_in     in   1           active-high tilt; blocks queuing of new coins
//  coin_n_out  out  NCOIN       active-low coin lines to the core
//  busy        out  1           high while any channel is non-IDLE or has pending coins
// BEHAVIOUR
//  Reset:
//   - coin_n_out = all 1s; busy = 0; all channels IDLE; pending = 0;
//     frame counters = 0; edge/vblank history registers = 0.
//   - Reset mid-pulse takes effect on the next edge and releases the line at once.
//  Frame tick:
//   - vblank is registered once (vb_q). tick = vblank & ~vb_q, one clk_sys wide.
//  Coin edge:
//   - rise[i] = coin_in[i] & ~coin_q[i] (coin_q is a registered copy).
//   - A held level counts as exactly one coin.
//  Pending counter (per channel):
//   - +1 on rise while tilt_in=0, saturating at max.
//   - -1 when IDLE leaves for ASSERT.
//   - Rise and consume in the same cycle leave the counter unchanged.
//   - Rise at saturation is dropped.
//   - tilt_in=1: rises are ignored and pending is cleared to 0. A pulse or gap
//     already in progress runs to completion.
//  FSM per channel (IDLE, ASSERT, GAP):
//   - IDLE:   pending!=0 -> ASSERT, cnt<=0.
//   - ASSERT: on tick, cnt==HOLD_FRAMES-1 -> GAP, cnt<=0; else cnt+1.
//   - GAP:    on tick, cnt==GAP_FRAMES-1 -> IDLE, cnt<=0; else cnt+1.
//   - cnt width: $clog2(max(HOLD_FRAMES,GAP_FRAMES)+1).
//   - A tick in the cycle the state is entered is not counted.
//  Outputs:
//   - coin_n_out[i] = ~(state[i]==ASSERT), decoded directly from the state register.
//   - busy = OR over channels of (state!=IDLE | pending!=0).
//  Latency:
//   - rise sampled at cycle t -> pending=1 at t+1 -> ASSERT and coin_n low at t+2.
//   - Pulse width: from ASSERT entry to the HOLD_FRAMES-th tick, inclusive.
//   - Line goes high the cycle after that tick.
//  Channels:
//   - Fully independent; simultaneous events on different channels do not interact.
// STRUCTURE
//  Shared package arcade_pkg:
//   - typedef enum logic [1:0] {CS_IDLE, CS_ASSERT, CS_GAP} coin_state_t;
//   - default-parameter localparams.
//  Top:
//   - vblank tick detector.
//   - Generate loop of NCOIN instances of the sub-module.
//   - busy OR-reduce.
//  Sub-module arcade_coin_chan:
//   - Edge detector, pending counter and FSM for one channel.
//   - Inputs: tick, coin, tilt. Outputs: coin_n, busy.
// TESTING (defaults; vblank period 100 clk, high for 10)
//  1. Single press on coin_in[0], held 500 clk:
//     coin_n_out=2'b10 from t+2 to 1 clk after the 3rd tick, then high.
//     No second pulse. busy drops after the 3rd GAP tick.
//  2. Five 1-clk presses on coin_in[0] within one frame:
//     - First goes straight to ASSERT; pending saturates at 3.
//     - Exactly 4 pulses total, separated by 3-tick gaps.
//  3. Same-cycle rises on coin_in[1:0]:
//     both lines low at t+2 and high together; coin_n_out = 2'b00 then 2'b11.
//  4. Tilt=1 during an ASSERT with pending=2:
//     - Current pulse and gap complete, pending becomes 0, no further pulses.
//     - Presses while tilt=1 are ignored.
//  5. reset asserted mid-ASSERT:
//     coin_n_out=2'b11 and busy=0 on the next edge. After release, a new press
//     gives a clean 3-tick pulse.
//  6. Rise coinciding with IDLE->ASSERT consume (pending=1):
//     pending stays 1 and a second pulse follows the gap.

Source files
------------

// File: rtl/arcade_coin_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_pkg : shared types and default parameters for coin sequencing |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arcade_pkg;

  typedef enum logic [1:0] {
    CS_IDLE   = 2'd0,
    CS_ASSERT = 2'd1,
    CS_GAP    = 2'd2
  } coin_state_t;

  localparam int c_ncoin_def       = 2;
  localparam int c_hold_frames_def = 3;
  localparam int c_gap_frames_def  = 3;
  localparam int c_pend_w_def      = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_coin_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_coin_seq_if : coin/tilt/vblank inputs and coin line outputs    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface arcade_coin_seq_if #(
  parameter int NCOIN = 2
);
  logic             vblank;
  logic [NCOIN-1:0] coin_in;
  logic             tilt_in;
  logic [NCOIN-1:0] coin_n_out;
  logic             busy;

  modport master (
    output vblank, coin_in, tilt_in,
    input  coin_n_out, busy
  );

  modport slave (
    input  vblank, coin_in, tilt_in,
    output coin_n_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/arcade_coin_seq_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_coin_chan : one coin channel - edge detect, pending queue, FSM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arcade_coin_chan
  import arcade_pkg::*;
#(
  parameter int HOLD_FRAMES = c_hold_frames_def,
  parameter int GAP_FRAMES  = c_gap_frames_def,
  parameter int PEND_W      = c_pend_w_def
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic coin,
  input  logic tilt,
  output logic coin_n,
  output logic busy
);

  localparam int c_cnt_w = $clog2(max_int(HOLD_FRAMES, GAP_FRAMES) + 1);
  localparam logic [PEND_W-1:0]  c_pend_max  = '1;
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_FRAMES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_FRAMES - 1);

  coin_state_t        r_state;
  coin_state_t        w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [PEND_W-1:0]  r_pend;
  logic [PEND_W-1:0]  w_pend_nxt;
  logic               r_coin_q;
  logic               w_rise;
  logic               w_consume;

  assign w_rise    = coin & ~r_coin_q;
  assign w_consume = (r_state == CS_IDLE) && (r_pend != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CS_IDLE;
      r_cnt    <= '0;
      r_pend   <= '0;
      r_coin_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_coin_q <= coin;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;

    // Tilt flushes the queue but never truncates a pulse or gap in flight.
    if (tilt) begin
      w_pend_nxt = '0;
    end else if (w_rise && !w_consume) begin
      if (r_pend != c_pend_max) w_pend_nxt = r_pend + PEND_W'(1);
    end else if (w_consume && !w_rise) begin
      w_pend_nxt = r_pend - PEND_W'(1);
    end

    case (r_state)
      CS_IDLE: begin
        if (r_pend != '0) begin
          w_state_nxt = CS_ASSERT;
          w_cnt_nxt   = '0;
        end
      end
      CS_ASSERT: begin
        if (tick) begin
          if (r_cnt == c_hold_last) begin
            w_state_nxt = CS_GAP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      CS_GAP: begin
        if (tick) begin
          if (r_cnt == c_gap_last) begin
            w_state_nxt = CS_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      default: begin
        w_state_nxt = CS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign coin_n = (r_state != CS_ASSERT);
  assign busy   = (r_state != CS_IDLE) || (r_pend != '0);

endmodule
`default_nettype wire

// File: rtl/arcade_coin_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arcade_coin_seq : replays raw coin presses as frame-timed pulses      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arcade_coin_seq
  import arcade_pkg::*;
#(
  parameter int NCOIN       = c_ncoin_def,
  parameter int HOLD_FRAMES = c_hold_frames_def,
  parameter int GAP_FRAMES  = c_gap_frames_def,
  parameter int PEND_W      = c_pend_w_def
) (
  input  logic               clk_sys,
  input  logic               reset,
  arcade_coin_seq_if.slave   bus
);

  logic             r_vb_q;
  logic             w_tick;
  logic [NCOIN-1:0] w_coin_n;
  logic [NCOIN-1:0] w_busy;

  always_ff @(posedge clk_sys) begin
    if (reset) r_vb_q <= 1'b0;
    else       r_vb_q <= bus.vblank;
  end

  // One clk_sys-wide pulse per frame, on the rising edge of vblank.
  assign w_tick = bus.vblank & ~r_vb_q;

  for (genvar gi = 0; gi < NCOIN; gi++) begin : g_chan
    arcade_coin_chan #(
      .HOLD_FRAMES (HOLD_FRAMES),
      .GAP_FRAMES  (GAP_FRAMES),
      .PEND_W      (PEND_W)
    ) u_chan (
      .clk    (clk_sys),
      .rst    (reset),
      .tick   (w_tick),
      .coin   (bus.coin_in[gi]),
      .tilt   (bus.tilt_in),
      .coin_n (w_coin_n[gi]),
      .busy   (w_busy[gi])
    );
  end

  assign bus.coin_n_out = w_coin_n;
  assign bus.busy       = |w_busy;

endmodule
`default_nettype wire
